// File: rtl/mux_rr_arbiter_pkg.sv
// Shared types and round-robin pick helper for mux_rr_arbiter.
package mux_arb_pkg;

  typedef enum logic {S_IDLE, S_GRANT} arb_state_t;

  localparam int unsigned MAX_OP = 32;

  typedef struct packed {
    logic       found;
    logic [4:0] idx;
  } rr_pick_t;

  // Scan last+1, last+2, ... modulo n; first set request wins.
  function automatic rr_pick_t rr_pick(input logic [MAX_OP-1:0] req,
                                       input logic [4:0]        last,
                                       input int unsigned       n);
    rr_pick_t    res;
    int unsigned j;
    res = '0;
    for (int unsigned i = 1; i <= MAX_OP; i++) begin
      if (i <= n && !res.found) begin
        j = 32'(last) + i;
        if (j >= n) j = j - n;
        if (req[j[4:0]]) begin
          res.found = 1'b1;
          res.idx   = j[4:0];
        end
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/mux_rr_arbiter_mux.sv
// Array mux: out = opt[in]; out-of-range selects yield zero.
module mux_arr_module #(
  parameter int WIDTH_OP  = 4,
  parameter int WIDTH_IN  = 2,
  parameter int WIDTH_BUS = 2
) (
  input  logic [WIDTH_IN-1:0]                in,
  input  logic [WIDTH_OP-1:0][WIDTH_BUS-1:0] opt,
  output logic [WIDTH_BUS-1:0]               out
);

  always_comb begin
    out = '0;
    for (int unsigned i = 0; i < WIDTH_OP; i++) begin
      if (in == WIDTH_IN'(i)) out = opt[i];
    end
  end

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin bus arbiter with registered one-hot grant and binary select.
// Optional owner preemption after HOLD_MAX cycles: define MUX_ARB_TIMEOUT_EN.
module mux_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int WIDTH_OP  = 4,
  parameter int WIDTH_IN  = 2,
  parameter int WIDTH_BUS = 2,
  parameter int HOLD_MAX  = 4
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [WIDTH_OP-1:0]                req,
  input  logic [WIDTH_OP-1:0][WIDTH_BUS-1:0] opt,
  output logic [WIDTH_OP-1:0]                gnt,
  output logic [WIDTH_IN-1:0]                sel,
  output logic [WIDTH_BUS-1:0]               out,
  output logic                               out_valid
);

  arb_state_t          state_q, state_d;
  logic [WIDTH_OP-1:0] gnt_q,   gnt_d;
  logic [WIDTH_IN-1:0] sel_q,   sel_d;
  logic [WIDTH_IN-1:0] last_q,  last_d;
  logic [MAX_OP-1:0]   req_ext;
  logic                owner_req;
  logic                preempt;
  rr_pick_t            pick;

`ifdef MUX_ARB_TIMEOUT_EN
  localparam int HW = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_MAX - 1);
  logic [HW-1:0] hold_q, hold_d;
  logic          others;
`endif

  always_comb begin
    req_ext                 = '0;
    req_ext[WIDTH_OP-1:0]   = req;
    pick                    = rr_pick(req_ext, 5'(last_q), WIDTH_OP);
    owner_req               = |(req & gnt_q);
    preempt                 = 1'b0;
    state_d                 = state_q;
    gnt_d                   = gnt_q;
    sel_d                   = sel_q;
    last_d                  = last_q;
`ifdef MUX_ARB_TIMEOUT_EN
    hold_d                  = hold_q;
    others                  = |(req & ~gnt_q);
`endif

    unique case (state_q)
      S_IDLE: begin
        gnt_d = '0;
        if (pick.found) begin
          state_d = S_GRANT;
          sel_d   = WIDTH_IN'(pick.idx);
          last_d  = WIDTH_IN'(pick.idx);
          gnt_d   = WIDTH_OP'(1) << pick.idx;
`ifdef MUX_ARB_TIMEOUT_EN
          hold_d  = '0;
`endif
        end
      end
      S_GRANT: begin
`ifdef MUX_ARB_TIMEOUT_EN
        // Counter saturates; preemption only fires when a rival is waiting.
        if (hold_q == HOLD_LAST) preempt = others;
        else                     hold_d  = hold_q + 1'b1;
`endif
        if (!owner_req || preempt) begin
          state_d = S_IDLE;
          gnt_d   = '0;
        end
      end
      default: begin
        state_d = S_IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      gnt_q   <= '0;
      sel_q   <= '0;
      last_q  <= WIDTH_IN'(WIDTH_OP - 1);
`ifdef MUX_ARB_TIMEOUT_EN
      hold_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
`ifdef MUX_ARB_TIMEOUT_EN
      hold_q  <= hold_d;
`endif
    end
  end

  assign gnt       = gnt_q;
  assign sel       = sel_q;
  assign out_valid = (state_q == S_GRANT);

  mux_arr_module #(
    .WIDTH_OP  (WIDTH_OP),
    .WIDTH_IN  (WIDTH_IN),
    .WIDTH_BUS (WIDTH_BUS)
  ) u_mux (
    .in  (sel_q),
    .opt (opt),
    .out (out)
  );

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Self-checking bench for mux_rr_arbiter: directed scenarios plus random traffic vs a queue-free model.
module tb_mux_rr_arbiter;

  localparam int N    = 4;
  localparam int HOLD = 4;
`ifdef MUX_ARB_TIMEOUT_EN
  localparam bit TIMEOUT = 1'b1;
`else
  localparam bit TIMEOUT = 1'b0;
`endif

  logic                 clk = 1'b0;
  logic                 rst = 1'b0;
  logic [N-1:0]         req = '0;
  logic [N-1:0][1:0]    opt = '0;
  logic [N-1:0]         gnt;
  logic [1:0]           sel;
  logic [1:0]           out;
  logic                 out_valid;

  int total = 0;
  int bad   = 0;

  // reference model: owner (-1 when idle), rotation pointer, select, cycles held
  int m_owner, m_last, m_sel, m_held;

  mux_rr_arbiter #(
    .WIDTH_OP  (N),
    .WIDTH_IN  (2),
    .WIDTH_BUS (2),
    .HOLD_MAX  (HOLD)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .opt       (opt),
    .gnt       (gnt),
    .sel       (sel),
    .out       (out),
    .out_valid (out_valid)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_owner = -1;
    m_last  = N - 1;
    m_sel   = 0;
    m_held  = 0;
  endtask

  task automatic model_step(input logic [N-1:0] r);
    logic [N-1:0] others;
    if (m_owner < 0) begin
      for (int k = 1; k <= N; k++) begin
        int idx;
        idx = (m_last + k) % N;
        if (m_owner < 0 && r[idx]) begin
          m_owner = idx;
          m_last  = idx;
          m_sel   = idx;
          m_held  = 1;
        end
      end
    end else begin
      others = r & ~(N'(1) << m_owner);
      if (!r[m_owner] || (TIMEOUT && m_held >= HOLD && others != '0)) m_owner = -1;
      else m_held++;
    end
  endtask

  // drive req, clock one edge, advance model, settle 1 time unit past the edge
  task automatic step(input logic [N-1:0] r);
    req = r;
    @(posedge clk);
    model_step(r);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    req = '0;
    rst = 1'b1;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    total++;
    if ({gnt, sel, out_valid} !== {4'b0000, 2'd0, 1'b0}) begin
      bad++;
      $display("FAIL reset: gnt=%b sel=%0d valid=%b want gnt=0000 sel=0 valid=0", gnt, sel, out_valid);
    end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_single();
    do_reset();
    opt = {2'b11, 2'b01, 2'b00, 2'b10};
    step(4'b0001);
    total++;
    if ({gnt, sel, out, out_valid} !== {4'b0001, 2'd0, 2'b10, 1'b1}) begin
      bad++;
      $display("FAIL single: gnt=%b sel=%0d out=%b valid=%b want 0001/0/10/1", gnt, sel, out, out_valid);
    end
  endtask

  task automatic test_handoff();
    do_reset();
    step(4'b1010);
    total++;
    if ({gnt, sel, out_valid} !== {4'b0010, 2'd1, 1'b1}) begin
      bad++;
      $display("FAIL handoff_first: gnt=%b sel=%0d valid=%b want 0010/1/1", gnt, sel, out_valid);
    end
    step(4'b1000);
    total++;
    if ({gnt, sel, out_valid} !== {4'b0000, 2'd1, 1'b0}) begin
      bad++;
      $display("FAIL handoff_bubble: gnt=%b sel=%0d valid=%b want 0000/1/0", gnt, sel, out_valid);
    end
    step(4'b1000);
    total++;
    if ({gnt, sel, out_valid} !== {4'b1000, 2'd3, 1'b1}) begin
      bad++;
      $display("FAIL handoff_second: gnt=%b sel=%0d valid=%b want 1000/3/1", gnt, sel, out_valid);
    end
  endtask

  // runs right after test_handoff with requester 3 still owning the bus
  task automatic test_wrap();
    step(4'b0001);
    total++;
    if ({gnt, out_valid} !== {4'b0000, 1'b0}) begin
      bad++;
      $display("FAIL wrap_bubble: gnt=%b valid=%b want 0000/0", gnt, out_valid);
    end
    step(4'b0001);
    total++;
    if ({gnt, sel, out_valid} !== {4'b0001, 2'd0, 1'b1}) begin
      bad++;
      $display("FAIL wrap_grant: gnt=%b sel=%0d valid=%b want 0001/0/1", gnt, sel, out_valid);
    end
  endtask

  task automatic test_timeout();
    logic [2:0] exp_seq [0:10];
    // {valid, sel}
    if (TIMEOUT)
      exp_seq = '{3'b100, 3'b100, 3'b100, 3'b100, 3'b000,
                  3'b101, 3'b101, 3'b101, 3'b101, 3'b001, 3'b100};
    else
      exp_seq = '{3'b100, 3'b100, 3'b100, 3'b100, 3'b100,
                  3'b100, 3'b100, 3'b100, 3'b100, 3'b100, 3'b100};
    do_reset();
    for (int c = 0; c < 11; c++) begin
      step(4'b0011);
      total++;
      if ({out_valid, sel} !== exp_seq[c]) begin
        bad++;
        $display("FAIL timeout_c%0d: valid=%b sel=%0d want valid=%b sel=%0d",
                 c, out_valid, sel, exp_seq[c][2], exp_seq[c][1:0]);
      end
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    step(4'b0100);
    total++;
    if ({gnt, sel} !== {4'b0100, 2'd2}) begin
      bad++;
      $display("FAIL arst_pre: gnt=%b sel=%0d want 0100/2", gnt, sel);
    end
    #2;
    rst = 1'b1;
    #1;
    total++;
    if ({gnt, sel, out_valid} !== {4'b0000, 2'd0, 1'b0}) begin
      bad++;
      $display("FAIL arst_drop: gnt=%b sel=%0d valid=%b want 0000/0/0", gnt, sel, out_valid);
    end
    #1;
    rst = 1'b0;
    model_reset();
    step(4'b0101);
    total++;
    if ({gnt, sel, out_valid} !== {4'b0001, 2'd0, 1'b1}) begin
      bad++;
      $display("FAIL arst_restart: gnt=%b sel=%0d valid=%b want 0001/0/1", gnt, sel, out_valid);
    end
  endtask

  task automatic test_mux_data();
    logic [1:0] exp_out [0:3];
    exp_out = '{2'b00, 2'b11, 2'b10, 2'b01};
    do_reset();
    opt = {2'b01, 2'b10, 2'b11, 2'b00};
    for (int i = 0; i < N; i++) begin
      step(N'(1) << i);
      total++;
      if ({sel, out, out_valid} !== {2'(i), exp_out[i], 1'b1}) begin
        bad++;
        $display("FAIL mux_data_%0d: sel=%0d out=%b valid=%b want sel=%0d out=%b valid=1",
                 i, sel, out, out_valid, i, exp_out[i]);
      end
      step(4'b0000);
    end
  endtask

  task automatic test_random();
    logic [N-1:0] r;
    logic [N-1:0] exp_gnt;
    do_reset();
    r = '0;
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 3) == 0) r = N'($urandom);
      opt = 8'($urandom);
      step(r);
      exp_gnt = (m_owner >= 0) ? (N'(1) << m_owner) : '0;
      total++;
      if ({gnt, sel, out, out_valid} !== {exp_gnt, 2'(m_sel), opt[m_sel], (m_owner >= 0)}) begin
        bad++;
        $display("FAIL random_c%0d: gnt=%b sel=%0d out=%b valid=%b want gnt=%b sel=%0d out=%b valid=%b",
                 c, gnt, sel, out, out_valid, exp_gnt, m_sel, opt[m_sel], (m_owner >= 0));
      end
    end
  endtask

  initial begin
    model_reset();
    rst = 1'b1;
    #12;
    rst = 1'b0;
    test_reset();
    test_single();
    test_handoff();
    test_wrap();
    test_timeout();
    test_async_reset();
    test_mux_data();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
